// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM types (pwm_mode_e: PWM_EDGE=0 sawtooth, PWM_CENTER=1 triangle)
package pwm_pkg;
  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: slot counter, main counter c, direction and period/mode latching; ports clk rst cfg_period cfg_mode -> c slot tick boundary
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PWM_WIDTH = 16,
  parameter int NUM_PWM = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PWM_WIDTH-1:0]       cfg_period,
  input  pwm_mode_e                  cfg_mode,
  output logic [PWM_WIDTH-1:0]       c,
  output logic [$clog2(NUM_PWM)-1:0] slot,
  output logic                       tick,
  output logic                       boundary
);
  localparam int SW = $clog2(NUM_PWM);
  logic [PWM_WIDTH-1:0] p;
  pwm_mode_e mode;
  logic down;
  assign tick = slot == SW'(NUM_PWM - 1);
  assign boundary = tick && (p == '0 || (mode == PWM_EDGE ? c == p : down && c == PWM_WIDTH'(1)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
      c <= '0;
      down <= 1'b0;
      p <= '0;
      mode <= PWM_EDGE;
    end else begin
      slot <= tick ? '0 : slot + 1'b1;
      if (boundary) begin
        c <= '0;
        down <= 1'b0;
        p <= cfg_period;
        mode <= cfg_mode;
      end else if (tick) begin
        c <= down ? c - 1'b1 : c + 1'b1;
        if (mode == PWM_CENTER && !down && c + 1'b1 == p) down <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/pwm_mux.sv
// pwm_mux: time-sliced N-channel PWM with double-buffered duty/pol; ports clk rst cfg_period cfg_mode wr_valid/wr_ready wr_chan wr_duty wr_pol -> pwm_out period_start
module pwm_mux
  import pwm_pkg::*;
#(
  parameter int PWM_WIDTH = 16,
  parameter int NUM_PWM = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PWM_WIDTH-1:0]       cfg_period,
  input  pwm_mode_e                  cfg_mode,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [$clog2(NUM_PWM)-1:0] wr_chan,
  input  logic [PWM_WIDTH-1:0]       wr_duty,
  input  logic                       wr_pol,
  output logic [NUM_PWM-1:0]         pwm_out,
  output logic                       period_start
);
  logic [PWM_WIDTH-1:0] c;
  logic [$clog2(NUM_PWM)-1:0] slot;
  logic tick, boundary, res;
  logic [PWM_WIDTH-1:0] sh_duty [NUM_PWM];
  logic [PWM_WIDTH-1:0] act_duty [NUM_PWM];
  logic [NUM_PWM-1:0] sh_pol, act_pol;
  logic [NUM_PWM-2:0] staging;
  pwm_timebase #(.PWM_WIDTH(PWM_WIDTH), .NUM_PWM(NUM_PWM)) u_tb (
    .clk(clk), .rst(rst), .cfg_period(cfg_period), .cfg_mode(cfg_mode),
    .c(c), .slot(slot), .tick(tick), .boundary(boundary)
  );
  assign wr_ready = !rst && !boundary;
  assign res = (c < act_duty[slot]) ^ act_pol[slot];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PWM; i++) begin
        sh_duty[i] <= '0;
        act_duty[i] <= '0;
      end
      sh_pol <= '0;
      act_pol <= '0;
    end else begin
      if (wr_valid && wr_ready && int'(wr_chan) < NUM_PWM) begin
        sh_duty[wr_chan] <= wr_duty;
        sh_pol[wr_chan] <= wr_pol;
      end
      if (boundary) begin
        act_duty <= sh_duty;
        act_pol <= sh_pol;
      end
    end
  end
  // last channel bypasses staging so the whole round lands on pwm_out at the tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging <= '0;
      pwm_out <= '0;
      period_start <= 1'b0;
    end else begin
      if (!tick) staging[slot] <= res;
      if (tick) pwm_out <= {res, staging};
      period_start <= boundary;
    end
  end
endmodule

// File: tb/tb_pwm_mux.sv
// tb_pwm_mux: randomized scoreboard bench for pwm_mux against a period-list reference model
module tb_pwm_mux;
  import pwm_pkg::*;
  localparam int W = 16, N = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] cfg_period = '0;
  pwm_mode_e cfg_mode = PWM_EDGE;
  logic wr_valid = 1'b0, wr_ready, wr_pol = 1'b0;
  logic [1:0] wr_chan = '0;
  logic [W-1:0] wr_duty = '0;
  logic [N-1:0] pwm_out;
  logic period_start;
  pwm_mux #(.PWM_WIDTH(W), .NUM_PWM(N)) dut (
    .clk(clk), .rst(rst), .cfg_period(cfg_period), .cfg_mode(cfg_mode),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan), .wr_duty(wr_duty),
    .wr_pol(wr_pol), .pwm_out(pwm_out), .period_start(period_start)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [N-1:0] out;
    logic ps;
  } exp_t;
  exp_t exp_q[$];
  int cq[$];
  int pos;
  int sh_d[N], act_d[N];
  bit sh_p[N], act_p[N];
  int cmp_n = 0, err_n = 0;
  logic [N-1:0] last_out = '0;
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    cmp_n++;
    if (act !== req) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  // one entry per round: the counter value that round sees, for the whole period
  task automatic build_period(int p, pwm_mode_e m);
    cq.delete();
    if (p == 0) cq.push_back(0);
    else begin
      for (int v = 0; v <= p; v++) cq.push_back(v);
      if (m == PWM_CENTER) for (int v = p - 1; v >= 1; v--) cq.push_back(v);
    end
  endtask
  function automatic bit exp_ready();
    return !(pos == N - 1 && cq.size() == 1);
  endfunction
  always @(posedge clk or posedge rst) begin
    int cv;
    exp_t e;
    if (rst) begin
      pos = 0;
      build_period(0, PWM_EDGE);
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
        sh_d[i] = 0; act_d[i] = 0; sh_p[i] = 0; act_p[i] = 0;
      end
    end else begin
      if (wr_valid && exp_ready()) begin
        sh_d[wr_chan] = int'(wr_duty);
        sh_p[wr_chan] = wr_pol;
      end
      if (pos == N - 1) begin
        cv = cq.pop_front();
        for (int i = 0; i < N; i++) e.out[i] = (cv < act_d[i]) ^ act_p[i];
        e.ps = cq.size() == 0;
        if (e.ps) begin
          act_d = sh_d;
          act_p = sh_p;
          build_period(int'(cfg_period), cfg_mode);
        end
        exp_q.push_back(e);
        pos = 0;
      end else pos++;
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rst_pwm_out", pwm_out, 0);
      check("rst_period_start", period_start, 0);
      check("rst_wr_ready", wr_ready, 0);
      last_out = '0;
    end else begin
      check("wr_ready", wr_ready, exp_ready());
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pwm_out", pwm_out, e.out);
        check("period_start", period_start, e.ps);
        last_out = e.out;
      end else begin
        check("pwm_out_hold", pwm_out, last_out);
        check("period_start_idle", period_start, 0);
      end
    end
  end
  task automatic wr(int ch, int d, bit p);
    int t = 0;
    @(negedge clk);
    wr_valid = 1'b1; wr_chan = 2'(ch); wr_duty = W'(d); wr_pol = p;
    while (!wr_ready && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (!wr_ready) check("wr_accept", wr_ready, 1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
  endtask
  task automatic cfg(int p, pwm_mode_e m);
    @(negedge clk);
    cfg_period = W'(p);
    cfg_mode = m;
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    int t;
    idle(3);
    #2 rst = 1'b0;
    cfg(9, PWM_EDGE);
    wr(0, 0, 0); wr(1, 5, 0); wr(2, 9, 0); wr(3, 10, 0);
    idle(130);
    cfg(8, PWM_CENTER);
    wr(1, 3, 0);
    idle(150);
    cfg(9, PWM_EDGE);
    wr(2, 4, 1);
    idle(100);
    wr(0, 7, 0);
    idle(95);
    wr(0, 2, 0);
    idle(80);
    cfg(3, PWM_CENTER);
    idle(80);
    cfg(0, PWM_EDGE);
    wr(0, 1, 0);
    idle(40);
    repeat (400) begin
      if ($urandom_range(0, 19) == 0) cfg($urandom_range(0, 6), pwm_mode_e'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) wr($urandom_range(0, N - 1), $urandom_range(0, 8), 1'($urandom_range(0, 1)));
      else idle(1);
    end
    cfg(2, PWM_EDGE);
    wr(3, 100, 0);
    idle(40);
    t = 0;
    while (pos != 2 && t < 8) begin
      @(negedge clk);
      t++;
    end
    #1 rst = 1'b1;
    #1;
    check("async_pwm_out", pwm_out, 0);
    check("async_period_start", period_start, 0);
    check("async_wr_ready", wr_ready, 0);
    idle(2);
    #2 rst = 1'b0;
    idle(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
